// File: rtl/ccsds123_out_fifo.sv
// Output FIFO for ccsds123_top: buffers the un-throttleable packed bitstream and re-emits it as
// narrower AXI4-Stream slices with backpressure. Optional word counter: CCSDS123_WORD_COUNT_EN.
module ccsds123_out_fifo #(
    parameter int BUS_WIDTH = 64,
    parameter int OUT_WIDTH = 32,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [BUS_WIDTH-1:0] in_tdata,
    input  logic                 in_tvalid,
    input  logic                 in_tlast,
    output logic [OUT_WIDTH-1:0] out_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic                 out_tlast,
    output logic [DEPTH_LOG:0]   level,
    output logic                 overflow
`ifdef CCSDS123_WORD_COUNT_EN
    ,
    output logic [31:0]          words_out
`endif
);

    localparam int RATIO = BUS_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_LEVEL = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(RATIO - 1);

    typedef enum logic {ST_RUN, ST_DROP} state_t;

    logic [BUS_WIDTH:0]   mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   level_q, level_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    state_t               state_q, state_d;
    logic                 overflow_q, overflow_d;

    logic                 full, not_empty, hs, pop, push;
    logic [BUS_WIDTH:0]   head_word;
    logic [OUT_WIDTH-1:0] head_slices [RATIO];

    assign head_word = mem[rd_ptr_q];

    // Slice 0 is the LSB slice so byte order of the packed stream is preserved.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        assign head_slices[gi] = head_word[gi*OUT_WIDTH +: OUT_WIDTH];
    end

    always_comb begin
        full       = (level_q == FULL_LEVEL);
        not_empty  = (level_q != '0);
        hs         = not_empty && out_tready;
        pop        = hs && (idx_q == IDX_LAST);
        push       = 1'b0;
        state_d    = state_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_RUN: begin
                if (in_tvalid) begin
                    // A pop this cycle frees the slot, so full+pop is still a clean accept.
                    if (!full || pop) begin
                        push = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                        if (!in_tlast) state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (in_tvalid && in_tlast) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;

        idx_d = idx_q;
        if (hs) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            idx_q      <= '0;
            state_q    <= ST_RUN;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {in_tlast, in_tdata};
    end

    // Outputs are gated by occupancy so stale storage never leaks out after reset.
    assign out_tvalid = not_empty;
    assign out_tdata  = not_empty ? head_slices[idx_q] : '0;
    assign out_tlast  = not_empty && head_word[BUS_WIDTH] && (idx_q == IDX_LAST);
    assign level      = level_q;
    assign overflow   = overflow_q;

`ifdef CCSDS123_WORD_COUNT_EN
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] words_out_q, words_out_d;

    always_comb begin
        word_cnt_d  = word_cnt_q;
        words_out_d = words_out_q;
        if (hs) begin
            if (out_tlast) begin
                words_out_d = word_cnt_q + 32'd1;
                word_cnt_d  = '0;
            end else begin
                word_cnt_d  = word_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            word_cnt_q  <= '0;
            words_out_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            words_out_q <= words_out_d;
        end
    end

    assign words_out = words_out_q;
`endif

endmodule
